// File: rtl/hazard_ctrl_v2.sv
// Hazard and forwarding controller for a D/E/M/W RV32 pipeline: operand forwarding
// selects, load-use and MDU stalls, and stretched branch/mret flushes.
module hazard_ctrl_v2 #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter bit MDU_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic [31:0] instr_M,
    input  logic [31:0] instr_W,
    input  logic        reg_write_E,
    input  logic        reg_write_M,
    input  logic        reg_write_W,
    input  logic        br_taken,
    input  logic        flush_mret,
    input  logic        mdu_busy,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        bubble_E,
    output logic        flush_D,
    output logic        flush_E,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MDUWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 7 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_param_err
            $error("hazard_ctrl_v2: LOAD_LAT and FLUSH_CYCLES must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    // Field decode
    logic [6:0] op_D;
    logic [6:0] op_E;
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic [4:0] rd_E;
    logic [4:0] rd_M;
    logic [4:0] rd_W;
    logic       use_rs1;
    logic       use_rs2;

    assign op_D  = instr_D[6:0];
    assign op_E  = instr_E[6:0];
    assign rs1_D = instr_D[19:15];
    assign rs2_D = instr_D[24:20];
    assign rd_E  = instr_E[11:7];
    assign rd_M  = instr_M[11:7];
    assign rd_W  = instr_W[11:7];

    assign use_rs1 = !(op_D inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign use_rs2 = op_D inside {OP_OP, OP_STORE, OP_BRANCH};

    logic unused_bits;
    assign unused_bits = ^{instr_D[31:25], instr_D[14:7], instr_E[31:12],
                           instr_M[31:12], instr_M[6:0], instr_W[31:12], instr_W[6:0]};

    function automatic logic src_match(input logic we, input logic [4:0] rd,
                                       input logic [4:0] src, input logic use_bit);
        return we && (rd != 5'd0) && (rd == src) && use_bit;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic m_e, input logic m_m, input logic m_w);
        if (m_e)      return 2'd1;
        else if (m_m) return 2'd2;
        else if (m_w) return 2'd3;
        else          return 2'd0;
    endfunction

    logic e_rs1, m_rs1, w_rs1;
    logic e_rs2, m_rs2, w_rs2;

    assign e_rs1 = src_match(reg_write_E, rd_E, rs1_D, use_rs1);
    assign m_rs1 = src_match(reg_write_M, rd_M, rs1_D, use_rs1);
    assign w_rs1 = src_match(reg_write_W, rd_W, rs1_D, use_rs1);
    assign e_rs2 = src_match(reg_write_E, rd_E, rs2_D, use_rs2);
    assign m_rs2 = src_match(reg_write_M, rd_M, rs2_D, use_rs2);
    assign w_rs2 = src_match(reg_write_W, rd_W, rs2_D, use_rs2);

    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    assign fwd_a_raw = fwd_sel(e_rs1, m_rs1, w_rs1);
    assign fwd_b_raw = fwd_sel(e_rs2, m_rs2, w_rs2);

    logic load_use;
    logic redirect;
    logic mdu_req;
    assign load_use = (op_E == OP_LOAD) && (e_rs1 || e_rs2);
    assign redirect = br_taken || flush_mret;
    assign mdu_req  = MDU_EN && mdu_busy;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall_fd;
    logic       stall_ex;
    logic       bubble;
    logic       flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The entry cycle of a stall or flush already counts as its first cycle, so
    // cnt holds the cycles still to spend in LDSTALL/FLUSH and the state is left
    // on the cycle that consumes the last one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_fd = 1'b0;
        stall_ex = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                RUN, MDUWAIT: begin
                    // MDUWAIT falls back to normal hazard evaluation once busy drops
                    if (mdu_req) begin
                        stall_fd = 1'b1;
                        stall_ex = 1'b1;
                        state_d  = MDUWAIT;
                    end else if (load_use) begin
                        stall_fd = 1'b1;
                        bubble   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = LOAD_RELOAD;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                LDSTALL: begin
                    stall_fd = 1'b1;
                    bubble   = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Outputs are gated by rst_n so they drop immediately on an asynchronous reset.
    assign fwdA     = (rst_n && state_q != FLUSH) ? fwd_a_raw : 2'd0;
    assign fwdB     = (rst_n && state_q != FLUSH) ? fwd_b_raw : 2'd0;
    assign stall_F  = rst_n && stall_fd;
    assign stall_D  = rst_n && stall_fd;
    assign stall_E  = rst_n && stall_ex;
    assign bubble_E = rst_n && bubble;
    assign flush_D  = rst_n && flush;
    assign flush_E  = rst_n && flush;
    assign state_o  = state_q;

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed bench for hazard_ctrl_v2: forwarding vector table plus hand-written
// load-use, MDU, flush and asynchronous reset sequences on two parameter sets.
module tb_hazard_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_D, instr_E, instr_M, instr_W;
    logic        reg_write_E, reg_write_M, reg_write_W;
    logic        br_taken, flush_mret, mdu_busy;

    // p: LOAD_LAT = 3, FLUSH_CYCLES = 2; s: LOAD_LAT = 1, FLUSH_CYCLES = 1
    logic [1:0] fwd_a_p, fwd_b_p, state_p, fwd_a_s, fwd_b_s, state_s;
    logic       stall_f_p, stall_d_p, stall_e_p, bubble_p, flush_d_p, flush_e_p;
    logic       stall_f_s, stall_d_s, stall_e_s, bubble_s, flush_d_s, flush_e_s;
    logic [7:0] ctl_p, ctl_s;

    assign ctl_p = {stall_f_p, stall_d_p, stall_e_p, bubble_p, flush_d_p, flush_e_p, state_p};
    assign ctl_s = {stall_f_s, stall_d_s, stall_e_s, bubble_s, flush_d_s, flush_e_s, state_s};

    hazard_ctrl_v2 #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .MDU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
        .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .br_taken(br_taken), .flush_mret(flush_mret), .mdu_busy(mdu_busy),
        .fwdA(fwd_a_p), .fwdB(fwd_b_p),
        .stall_F(stall_f_p), .stall_D(stall_d_p), .stall_E(stall_e_p), .bubble_E(bubble_p),
        .flush_D(flush_d_p), .flush_E(flush_e_p), .state_o(state_p)
    );

    hazard_ctrl_v2 #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .MDU_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
        .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .br_taken(br_taken), .flush_mret(flush_mret), .mdu_busy(mdu_busy),
        .fwdA(fwd_a_s), .fwdB(fwd_b_s),
        .stall_F(stall_f_s), .stall_D(stall_d_s), .stall_E(stall_e_s), .bubble_E(bubble_s),
        .flush_D(flush_d_s), .flush_E(flush_e_s), .state_o(state_s)
    );

    // clock
    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sb(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'b00110, op};
    endfunction

    typedef struct {
        logic [31:0] d, e, m, w;
        logic        rwe, rwm, rww;
        logic [1:0]  fa, fb;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act[7:0], exp[7:0], $time);
        end
    endtask

    task automatic clear_inputs();
        instr_D = NOP; instr_E = NOP; instr_M = NOP; instr_W = NOP;
        reg_write_E = 1'b0; reg_write_M = 1'b0; reg_write_W = 1'b0;
        br_taken = 1'b0; flush_mret = 1'b0; mdu_busy = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // d, e, m, w, rwE, rwM, rwW, fwdA, fwdB
        vecs[0]  = '{enc_r(6, 5, 5), enc_r(5, 1, 2), enc_addi(5, 1, 12'd4), NOP, 1, 1, 0, 2'd1, 2'd1};
        vecs[1]  = '{enc_r(6, 5, 5), enc_r(5, 1, 2), enc_addi(5, 1, 12'd4), NOP, 0, 1, 0, 2'd2, 2'd2};
        vecs[2]  = '{enc_r(6, 5, 5), enc_r(7, 1, 2), enc_addi(7, 1, 12'd4), enc_addi(5, 0, 12'd1), 1, 1, 1, 2'd3, 2'd3};
        vecs[3]  = '{enc_r(6, 5, 5), enc_r(0, 1, 2), enc_addi(5, 1, 12'd4), NOP, 1, 1, 0, 2'd2, 2'd2};
        vecs[4]  = '{enc_r(6, 0, 0), enc_r(0, 1, 2), enc_addi(0, 1, 12'd4), NOP, 1, 1, 0, 2'd0, 2'd0};
        vecs[5]  = '{{20'h00008, 5'd1, 7'b0110111}, enc_r(1, 2, 3), NOP, NOP, 1, 0, 0, 2'd0, 2'd0};
        vecs[6]  = '{enc_addi(9, 2, 12'd5), enc_r(5, 1, 2), NOP, NOP, 1, 0, 0, 2'd0, 2'd0};
        vecs[7]  = '{enc_addi(9, 5, 12'd5), enc_r(5, 1, 2), NOP, NOP, 1, 0, 0, 2'd1, 2'd0};
        vecs[8]  = '{enc_sb(7'b0100011, 2, 5), enc_r(5, 1, 2), enc_r(2, 1, 1), NOP, 1, 1, 0, 2'd2, 2'd1};
        vecs[9]  = '{enc_sb(7'b1100011, 3, 4), NOP, enc_r(3, 1, 1), enc_r(4, 1, 1), 0, 1, 1, 2'd2, 2'd3};
        vecs[10] = '{{20'h00008, 5'd1, 7'b1101111}, enc_r(1, 2, 3), NOP, NOP, 1, 0, 0, 2'd0, 2'd0};
        vecs[11] = '{enc_r(6, 5, 8), NOP, NOP, enc_r(5, 1, 1), 0, 0, 0, 2'd0, 2'd0};
        vecs[12] = '{enc_r(6, 8, 5), enc_r(5, 1, 2), enc_r(8, 1, 1), enc_r(5, 1, 1), 1, 1, 1, 2'd2, 2'd1};

        // reset: outputs forced low even with a forwarding match and a redirect pending
        clear_inputs();
        rst_n = 1'b0;
        instr_D = enc_r(6, 5, 5); instr_E = enc_r(5, 1, 2); reg_write_E = 1'b1; flush_mret = 1'b1;
        #3;
        check("reset_fwd_a", {30'd0, fwd_a_p}, 32'd0);
        check("reset_ctl_p", {24'd0, ctl_p}, 32'd0);
        check("reset_ctl_s", {24'd0, ctl_s}, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        check("post_reset_ctl", {24'd0, ctl_p}, 32'd0);

        // forwarding table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            instr_D = vecs[i].d; instr_E = vecs[i].e; instr_M = vecs[i].m; instr_W = vecs[i].w;
            reg_write_E = vecs[i].rwe; reg_write_M = vecs[i].rwm; reg_write_W = vecs[i].rww;
            #1;
            check($sformatf("vec%0d_fwdA", i), {30'd0, fwd_a_p}, {30'd0, vecs[i].fa});
            check($sformatf("vec%0d_fwdB", i), {30'd0, fwd_b_p}, {30'd0, vecs[i].fb});
            check($sformatf("vec%0d_fwdA_s", i), {30'd0, fwd_a_s}, {30'd0, vecs[i].fa});
            check($sformatf("vec%0d_ctl", i), {24'd0, ctl_p}, 32'd0);
        end
        idle(2);

        // load-use: p stalls 3 cycles, s stalls 1
        instr_D = enc_r(4, 3, 1); instr_E = enc_lw(3, 2); reg_write_E = 1'b1;
        #1;
        check("ld_c1_p", {24'd0, ctl_p}, 32'b1101_0000);
        check("ld_c1_s", {24'd0, ctl_s}, 32'b1101_0000);
        @(negedge clk);
        instr_E = NOP; reg_write_E = 1'b0; instr_M = enc_lw(3, 2); reg_write_M = 1'b1;
        #1;
        check("ld_c2_p", {24'd0, ctl_p}, 32'b1101_0001);
        check("ld_c2_s", {24'd0, ctl_s}, 32'd0);
        check("ld_c2_fwdA_s", {30'd0, fwd_a_s}, 32'd2);
        @(negedge clk); #1;
        check("ld_c3_p", {24'd0, ctl_p}, 32'b1101_0001);
        @(negedge clk); #1;
        check("ld_c4_p", {24'd0, ctl_p}, 32'd0);
        check("ld_c4_fwdA_p", {30'd0, fwd_a_p}, 32'd2);
        idle(2);

        // MDU wait for 5 busy cycles
        for (int c = 1; c <= 5; c++) begin
            mdu_busy = 1'b1;
            #1;
            check($sformatf("mdu_c%0d_p", c), {24'd0, ctl_p}, (c == 1) ? 32'b1110_0000 : 32'b1110_0010);
            check($sformatf("mdu_c%0d_s", c), {24'd0, ctl_s}, (c == 1) ? 32'b1110_0000 : 32'b1110_0010);
            @(negedge clk);
        end
        mdu_busy = 1'b0;
        #1;
        check("mdu_done_p", {24'd0, ctl_p}, 32'b0000_0010);
        @(negedge clk); #1;
        check("mdu_after_p", {24'd0, ctl_p}, 32'd0);
        idle(1);

        // single branch pulse; fwd forced off while in FLUSH
        instr_D = enc_r(6, 5, 5); instr_E = enc_r(5, 1, 2); reg_write_E = 1'b1; br_taken = 1'b1;
        #1;
        check("fl1_c1_p", {24'd0, ctl_p}, 32'b0000_1100);
        check("fl1_c1_s", {24'd0, ctl_s}, 32'b0000_1100);
        check("fl1_c1_fwdA", {30'd0, fwd_a_p}, 32'd1);
        @(negedge clk); br_taken = 1'b0; #1;
        check("fl1_c2_p", {24'd0, ctl_p}, 32'b0000_1111);
        check("fl1_c2_s", {24'd0, ctl_s}, 32'd0);
        check("fl1_c2_fwdA_p", {30'd0, fwd_a_p}, 32'd0);
        check("fl1_c2_fwdA_s", {30'd0, fwd_a_s}, 32'd1);
        @(negedge clk); #1;
        check("fl1_c3_p", {24'd0, ctl_p}, 32'd0);
        check("fl1_c3_fwdA_p", {30'd0, fwd_a_p}, 32'd1);
        idle(2);

        // second pulse during the stretch extends it to 3 cycles
        br_taken = 1'b1;
        #1; check("fl2_c1_p", {24'd0, ctl_p}, 32'b0000_1100);
        @(negedge clk); #1;
        check("fl2_c2_p", {24'd0, ctl_p}, 32'b0000_1111);
        check("fl2_c2_s", {24'd0, ctl_s}, 32'b0000_1100);
        @(negedge clk); br_taken = 1'b0; #1;
        check("fl2_c3_p", {24'd0, ctl_p}, 32'b0000_1111);
        check("fl2_c3_s", {24'd0, ctl_s}, 32'd0);
        @(negedge clk); #1;
        check("fl2_c4_p", {24'd0, ctl_p}, 32'd0);
        idle(2);

        // branch with load-use in the same cycle: flush only
        instr_D = enc_r(4, 3, 1); instr_E = enc_lw(3, 2); reg_write_E = 1'b1; br_taken = 1'b1;
        #1;
        check("fl_ld_c1_p", {24'd0, ctl_p}, 32'b0000_1100);
        check("fl_ld_c1_s", {24'd0, ctl_s}, 32'b0000_1100);
        @(negedge clk);
        br_taken = 1'b0; instr_E = NOP; reg_write_E = 1'b0; instr_M = enc_lw(3, 2); reg_write_M = 1'b1;
        #1;
        check("fl_ld_c2_p", {24'd0, ctl_p}, 32'b0000_1111);
        check("fl_ld_c2_s", {24'd0, ctl_s}, 32'd0);
        @(negedge clk); #1;
        check("fl_ld_c3_p", {24'd0, ctl_p}, 32'd0);
        idle(2);

        // mret redirect
        flush_mret = 1'b1;
        #1; check("mret_c1_p", {24'd0, ctl_p}, 32'b0000_1100);
        @(negedge clk); flush_mret = 1'b0; #1;
        check("mret_c2_p", {24'd0, ctl_p}, 32'b0000_1111);
        idle(2);

        // redirect while waiting on the MDU still wins
        mdu_busy = 1'b1;
        #1; check("mdu_br_c1_p", {24'd0, ctl_p}, 32'b1110_0000);
        @(negedge clk); br_taken = 1'b1; #1;
        check("mdu_br_c2_p", {24'd0, ctl_p}, 32'b0000_1110);
        @(negedge clk); br_taken = 1'b0; mdu_busy = 1'b0; #1;
        check("mdu_br_c3_p", {24'd0, ctl_p}, 32'b0000_1111);
        check("mdu_br_c3_s", {24'd0, ctl_s}, 32'd0);
        @(negedge clk); #1;
        check("mdu_br_c4_p", {24'd0, ctl_p}, 32'd0);
        idle(2);

        // asynchronous reset in the middle of a 3-cycle load stall
        instr_D = enc_r(4, 3, 1); instr_E = enc_lw(3, 2); reg_write_E = 1'b1;
        #1; check("rst_ld_c1_p", {24'd0, ctl_p}, 32'b1101_0000);
        @(negedge clk);
        instr_E = NOP; reg_write_E = 1'b0; instr_M = enc_lw(3, 2); reg_write_M = 1'b1;
        #1; check("rst_ld_c2_p", {24'd0, ctl_p}, 32'b1101_0001);
        #2; rst_n = 1'b0;
        #1;
        check("rst_mid_ctl_p", {24'd0, ctl_p}, 32'd0);
        check("rst_mid_fwdA_p", {30'd0, fwd_a_p}, 32'd0);
        flush_mret = 1'b1;
        #1; check("rst_mid_flush_p", {24'd0, ctl_p}, 32'd0);
        flush_mret = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("rst_rel_ctl_p", {24'd0, ctl_p}, 32'd0);
        check("rst_rel_fwdA_p", {30'd0, fwd_a_p}, 32'd2);
        @(negedge clk); #1;
        check("rst_rel_c2_p", {24'd0, ctl_p}, 32'd0);
        @(negedge clk); #1;
        check("rst_rel_c3_p", {24'd0, ctl_p}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
